uart_tx_frame: RTL and testbench

Parametrised UART transmit serializer. It accepts one parallel word per frame through a load/ready handshake and shifts it out LSB-first on `txd` as start bit, DATA_W data bits, an optional parity bit, and 1 or 2 stop bits. Bit timing is paced entirely by the external single-cycle baud strobe `txen`. The block sits between the host-side data source and the UART pin, alongside the baud generator that produces `txen`.

---
 rtl/uart_tx_frame_if.sv | 30 +++
 rtl/uart_tx_frame.sv | 157 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: host-side bundle for the UART transmit serializer.
//
// Handshake: a word transfers on the rising clk edge where load && ready.
// A load while ready is low is dropped. It is neither queued nor remembered,
// and load does not have to be held. txen is a free-running one-clk strobe
// from the baud generator, with one pulse per bit period. It carries no
// handshake.
interface uart_tx_frame_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              load;
    logic              txen;
    logic              ready;
    logic              busy;
    logic              frame_done;
    logic              txd;

    // Host / baud-generator side
    modport master (
        output tx_data, load, txen,
        input  ready, busy, frame_done, txd
    );

    // Serializer side
    modport slave (
        input  tx_data, load, txen,
        output ready, busy, frame_done, txd
    );
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit serializer. It sends the start bit, then
// DATA_W data bits LSB-first, then an optional parity bit, then STOP_BITS
// stop bits. The baud strobe txen paces every bit.
// Optional feature: define UART_TX_PARITY_EN to compile in the parity bit
// and the PAR state. PARITY_ODD selects odd parity when it is 1.
module uart_tx_frame #(
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                  clk,
    input  logic                  n_rst,
    uart_tx_frame_if.slave        bus,
    output logic [2:0]            dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_PAR   = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    localparam logic [3:0] BIT_LAST  = 4'(DATA_W - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              txd_q, txd_d;
    logic              frame_done_q, frame_done_d;

`ifdef UART_TX_PARITY_EN
    // Parity of the accepted word, captured at accept time so that later
    // changes on tx_data and the shifting of sh_q cannot disturb it.
    logic par_q, par_d;
`else
    // PARITY_ODD has no effect when parity is not compiled in.
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    // State and datapath registers. txd idles high out of reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            sh_q         <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            txd_q        <= 1'b1;
            frame_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            txd_q        <= txd_d;
            frame_done_q <= frame_done_d;
`ifdef UART_TX_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    // Next-state and next-output logic. txd_d is the level for the bit that
    // starts on this txen edge.
    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        txd_d        = txd_q;
        frame_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d        = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                // txen is ignored here. The start bit waits for the next strobe.
                if (bus.load) begin
                    sh_d       = bus.tx_data;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d      = (^bus.tx_data) ^ PARITY_ODD;
`endif
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.txen) begin
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bus.txen) begin
                    txd_d     = sh_q[0];
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.txen) begin
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = par_q;
                        state_d = S_PAR;
`else
                        txd_d   = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        sh_d      = sh_q >> 1;
                        txd_d     = sh_q[1];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PAR: begin
                if (bus.txen) begin
                    txd_d   = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bus.txen) begin
                    txd_d = 1'b1;
                    if (stop_cnt_q == STOP_LAST) begin
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake status is decoded straight from the state register.
    assign bus.ready      = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.txd        = txd_q;
    assign bus.frame_done = frame_done_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed checks of uart_tx_frame. It uses a default
// 8-bit / 1-stop instance and a 7-bit / 2-stop instance. With
// UART_TX_PARITY_EN defined, the bench also uses an odd-parity instance.
// Frame vectors list the bits LSB-first. Bit 0 is the start bit. The bits
// above the frame are 1, which is the idle level after the last stop bit.
`timescale 1ns/1ps
module tb_uart_tx_frame;
    logic clk = 1'b0;
    logic n_rst;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_frame_if #(.DATA_W(8)) if8();
    uart_tx_frame_if #(.DATA_W(7)) if7();
    logic [2:0] dbg8, dbg7;

    uart_tx_frame #(.DATA_W(8), .STOP_BITS(1), .PARITY_ODD(1'b0)) u_dut8 (
        .clk(clk), .n_rst(n_rst), .bus(if8), .dbg_state_o(dbg8)
    );
    uart_tx_frame #(.DATA_W(7), .STOP_BITS(2), .PARITY_ODD(1'b0)) u_dut7 (
        .clk(clk), .n_rst(n_rst), .bus(if7), .dbg_state_o(dbg7)
    );

`ifdef UART_TX_PARITY_EN
    uart_tx_frame_if #(.DATA_W(8)) ifo();
    logic [2:0] dbgo;
    uart_tx_frame #(.DATA_W(8), .STOP_BITS(1), .PARITY_ODD(1'b1)) u_dut_odd (
        .clk(clk), .n_rst(n_rst), .bus(ifo), .dbg_state_o(dbgo)
    );
    localparam int N8 = 11;
    localparam int N7 = 11;
    // 0xA5, 0x3C and 0x55 each have four ones, so their even parity is 0.
    localparam logic [11:0] F8_A5  = {1'b1, 1'b1, 1'b0, 8'hA5, 1'b0};
    localparam logic [11:0] F8_3C  = {1'b1, 1'b1, 1'b0, 8'h3C, 1'b0};
    localparam logic [11:0] F8_55  = {1'b1, 1'b1, 1'b0, 8'h55, 1'b0};
    localparam logic [11:0] F7_55  = {1'b1, 2'b11, 1'b0, 7'h55, 1'b0};
    localparam logic [11:0] FO_A5  = {1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
`else
    localparam int N8 = 10;
    localparam int N7 = 10;
    localparam logic [11:0] F8_A5  = {2'b11, 1'b1, 8'hA5, 1'b0};
    localparam logic [11:0] F8_3C  = {2'b11, 1'b1, 8'h3C, 1'b0};
    localparam logic [11:0] F8_55  = {2'b11, 1'b1, 8'h55, 1'b0};
    localparam logic [11:0] F7_55  = {2'b11, 2'b11, 7'h55, 1'b0};
`endif

    // Advance n clocks and settle 1 ns past the edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        if8.load = 1'b0; if8.txen = 1'b0; if8.tx_data = '0;
        if7.load = 1'b0; if7.txen = 1'b0; if7.tx_data = '0;
`ifdef UART_TX_PARITY_EN
        ifo.load = 1'b0; ifo.txen = 1'b0; ifo.tx_data = '0;
`endif
        cyc(2);
        vec_cnt++; if (if8.ready !== 1'b1) begin err_cnt++; $display("FAIL reset ready8: got %b want 1", if8.ready); end
        vec_cnt++; if (if8.busy !== 1'b0) begin err_cnt++; $display("FAIL reset busy8: got %b want 0", if8.busy); end
        vec_cnt++; if (if8.txd !== 1'b1) begin err_cnt++; $display("FAIL reset txd8: got %b want 1", if8.txd); end
        vec_cnt++; if (if8.frame_done !== 1'b0) begin err_cnt++; $display("FAIL reset done8: got %b want 0", if8.frame_done); end
        vec_cnt++; if (dbg8 !== 3'd0) begin err_cnt++; $display("FAIL reset state8: got %0d want 0", dbg8); end
        vec_cnt++; if (if7.txd !== 1'b1 || if7.ready !== 1'b1) begin err_cnt++; $display("FAIL reset dut7: got txd %b ready %b want 1 1", if7.txd, if7.ready); end
        n_rst = 1'b1;
        cyc(1);
    endtask

    // 0xA5 with txen every 4 clocks. The line holds idle while waiting for txen.
    task automatic test_basic_a5();
        logic [11:0] f;
        f = F8_A5;
        if8.tx_data = 8'hA5; if8.load = 1'b1;
        cyc(1);
        if8.load = 1'b0; if8.tx_data = 8'h00;
        vec_cnt++; if (if8.ready !== 1'b0 || if8.busy !== 1'b1) begin err_cnt++; $display("FAIL basic accept: got ready %b busy %b want 0 1", if8.ready, if8.busy); end
        cyc(2);
        vec_cnt++; if (if8.txd !== 1'b1) begin err_cnt++; $display("FAIL basic wait txd: got %b want 1", if8.txd); end
        for (int i = 0; i <= N8; i++) begin
            if8.txen = 1'b1;
            cyc(1);
            if8.txen = 1'b0;
            vec_cnt++; if (if8.txd !== f[i]) begin err_cnt++; $display("FAIL basic bit %0d: got %b want %b", i, if8.txd, f[i]); end
            vec_cnt++; if (if8.frame_done !== (i == N8)) begin err_cnt++; $display("FAIL basic done %0d: got %b want %b", i, if8.frame_done, (i == N8)); end
            cyc(3);
            vec_cnt++; if (if8.txd !== f[i] || if8.frame_done !== 1'b0) begin err_cnt++; $display("FAIL basic hold %0d: got txd %b done %b want %b 0", i, if8.txd, if8.frame_done, f[i]); end
        end
        vec_cnt++; if (if8.ready !== 1'b1) begin err_cnt++; $display("FAIL basic end ready: got %b want 1", if8.ready); end
    endtask

    // A load of 0x3C during the 0xA5 frame is dropped. A later load sends 0x3C.
    task automatic test_load_busy();
        logic [11:0] f;
        f = F8_A5;
        if8.tx_data = 8'hA5; if8.load = 1'b1;
        cyc(1);
        if8.load = 1'b0;
        for (int i = 0; i <= N8; i++) begin
            if8.txen = 1'b1;
            cyc(1);
            if8.txen = 1'b0;
            vec_cnt++; if (if8.txd !== f[i]) begin err_cnt++; $display("FAIL busyload bit %0d: got %b want %b", i, if8.txd, f[i]); end
            if (i == 3) begin
                if8.tx_data = 8'h3C; if8.load = 1'b1;
            end
            cyc(1);
            if8.load = 1'b0;
            cyc(2);
        end
        vec_cnt++; if (if8.ready !== 1'b1) begin err_cnt++; $display("FAIL busyload queued: got ready %b want 1", if8.ready); end
        f = F8_3C;
        if8.load = 1'b1;
        cyc(1);
        if8.load = 1'b0; if8.tx_data = 8'hFF;
        for (int i = 0; i <= N8; i++) begin
            if8.txen = 1'b1;
            cyc(1);
            if8.txen = 1'b0;
            vec_cnt++; if (if8.txd !== f[i]) begin err_cnt++; $display("FAIL relo3c bit %0d: got %b want %b", i, if8.txd, f[i]); end
            vec_cnt++; if (if8.frame_done !== (i == N8)) begin err_cnt++; $display("FAIL relo3c done %0d: got %b want %b", i, if8.frame_done, (i == N8)); end
            cyc(3);
        end
    endtask

    // A load and a txen in the same IDLE cycle do not start the start bit.
    task automatic test_load_txen();
        logic [11:0] f;
        f = F8_55;
        if8.tx_data = 8'h55; if8.load = 1'b1; if8.txen = 1'b1;
        cyc(1);
        if8.load = 1'b0; if8.txen = 1'b0;
        vec_cnt++; if (if8.txd !== 1'b1 || if8.ready !== 1'b0) begin err_cnt++; $display("FAIL ldtxen accept: got txd %b ready %b want 1 0", if8.txd, if8.ready); end
        cyc(3);
        for (int i = 0; i <= N8; i++) begin
            if8.txen = 1'b1;
            cyc(1);
            if8.txen = 1'b0;
            vec_cnt++; if (if8.txd !== f[i]) begin err_cnt++; $display("FAIL ldtxen bit %0d: got %b want %b", i, if8.txd, f[i]); end
            cyc(3);
        end
    endtask

    // With txen held high, the bench loads 0x3C on the first ready cycle
    // after the 0xA5 frame.
    task automatic test_back_to_back();
        logic [11:0] f;
        f = F8_A5;
        if8.tx_data = 8'hA5; if8.load = 1'b1;
        cyc(1);
        if8.load = 1'b0; if8.txen = 1'b1;
        for (int i = 0; i <= N8; i++) begin
            cyc(1);
            vec_cnt++; if (if8.txd !== f[i]) begin err_cnt++; $display("FAIL b2b first bit %0d: got %b want %b", i, if8.txd, f[i]); end
            vec_cnt++; if (if8.frame_done !== (i == N8)) begin err_cnt++; $display("FAIL b2b first done %0d: got %b want %b", i, if8.frame_done, (i == N8)); end
        end
        vec_cnt++; if (if8.ready !== 1'b1) begin err_cnt++; $display("FAIL b2b ready: got %b want 1", if8.ready); end
        f = F8_3C;
        if8.tx_data = 8'h3C; if8.load = 1'b1;
        cyc(1);
        if8.load = 1'b0;
        vec_cnt++; if (if8.txd !== 1'b1 || if8.frame_done !== 1'b0) begin err_cnt++; $display("FAIL b2b accept: got txd %b done %b want 1 0", if8.txd, if8.frame_done); end
        for (int i = 0; i <= N8; i++) begin
            cyc(1);
            vec_cnt++; if (if8.txd !== f[i]) begin err_cnt++; $display("FAIL b2b second bit %0d: got %b want %b", i, if8.txd, f[i]); end
        end
        if8.txen = 1'b0;
        cyc(1);
        vec_cnt++; if (if8.frame_done !== 1'b0) begin err_cnt++; $display("FAIL b2b pulse width: got %b want 0", if8.frame_done); end
    endtask

    // The bench drops the reset mid-frame while the DUT is in DATA, then
    // sends a complete 0xA5 frame.
    task automatic test_reset_mid();
        logic [11:0] f;
        if8.tx_data = 8'h3C; if8.load = 1'b1;
        cyc(1);
        if8.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if8.txen = 1'b1;
            cyc(1);
            if8.txen = 1'b0;
            cyc(3);
        end
        vec_cnt++; if (if8.busy !== 1'b1) begin err_cnt++; $display("FAIL rstmid pre busy: got %b want 1", if8.busy); end
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        vec_cnt++; if (if8.txd !== 1'b1 || if8.ready !== 1'b1) begin err_cnt++; $display("FAIL rstmid async: got txd %b ready %b want 1 1", if8.txd, if8.ready); end
        vec_cnt++; if (if8.frame_done !== 1'b0) begin err_cnt++; $display("FAIL rstmid done: got %b want 0", if8.frame_done); end
        cyc(1);
        n_rst = 1'b1;
        cyc(4);
        vec_cnt++; if (if8.frame_done !== 1'b0 || if8.txd !== 1'b1) begin err_cnt++; $display("FAIL rstmid after: got done %b txd %b want 0 1", if8.frame_done, if8.txd); end
        f = F8_A5;
        if8.tx_data = 8'hA5; if8.load = 1'b1;
        cyc(1);
        if8.load = 1'b0;
        for (int i = 0; i <= N8; i++) begin
            if8.txen = 1'b1;
            cyc(1);
            if8.txen = 1'b0;
            vec_cnt++; if (if8.txd !== f[i]) begin err_cnt++; $display("FAIL rstmid frame bit %0d: got %b want %b", i, if8.txd, f[i]); end
            vec_cnt++; if (if8.frame_done !== (i == N8)) begin err_cnt++; $display("FAIL rstmid frame done %0d: got %b want %b", i, if8.frame_done, (i == N8)); end
            cyc(3);
        end
    endtask

    // Seven data bits with two stop bits: 0x55 with txen every 4 clocks.
    task automatic test_seven_two_stop();
        logic [11:0] f;
        f = F7_55;
        if7.tx_data = 7'h55; if7.load = 1'b1;
        cyc(1);
        if7.load = 1'b0;
        for (int i = 0; i <= N7; i++) begin
            if7.txen = 1'b1;
            cyc(1);
            if7.txen = 1'b0;
            vec_cnt++; if (if7.txd !== f[i]) begin err_cnt++; $display("FAIL d7s2 bit %0d: got %b want %b", i, if7.txd, f[i]); end
            vec_cnt++; if (if7.frame_done !== (i == N7)) begin err_cnt++; $display("FAIL d7s2 done %0d: got %b want %b", i, if7.frame_done, (i == N7)); end
            vec_cnt++; if (if7.ready !== (i == N7)) begin err_cnt++; $display("FAIL d7s2 ready %0d: got %b want %b", i, if7.ready, (i == N7)); end
            cyc(3);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    // Odd parity on 0xA5 gives a parity bit of 1.
    task automatic test_parity_odd();
        logic [11:0] f;
        f = FO_A5;
        ifo.tx_data = 8'hA5; ifo.load = 1'b1;
        cyc(1);
        ifo.load = 1'b0; ifo.txen = 1'b1;
        for (int i = 0; i <= N8; i++) begin
            cyc(1);
            vec_cnt++; if (ifo.txd !== f[i]) begin err_cnt++; $display("FAIL oddpar bit %0d: got %b want %b", i, ifo.txd, f[i]); end
            vec_cnt++; if (ifo.frame_done !== (i == N8)) begin err_cnt++; $display("FAIL oddpar done %0d: got %b want %b", i, ifo.frame_done, (i == N8)); end
        end
        ifo.txen = 1'b0;
        cyc(1);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_a5();
        test_load_busy();
        test_load_txen();
        test_back_to_back();
        test_reset_mid();
        test_seven_two_stop();
`ifdef UART_TX_PARITY_EN
        test_parity_odd();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
